// File: rtl/u_rca_seq_add_pkg.sv
// Shared constants and state type for the word-serial ripple-carry adder.
package u_rca_seq_add_pkg;

    localparam int WORD_W_DEF    = 32;
    localparam int NUM_WORDS_DEF = 4;

    typedef enum logic {
        FIRST = 1'b0,
        CHAIN = 1'b1
    } state_t;

endpackage

// File: rtl/u_rca_cin.sv
// Combinational WORD_W-bit ripple-carry adder with carry-in; one full-adder cell per bit.
module u_rca_cin
    import u_rca_seq_add_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W:0] c;

    assign c[0] = cin;

    // Bit 0 uses a full cell too so cin enters the chain like any other carry.
    for (genvar i = 0; i < WORD_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WORD_W];

endmodule

// File: rtl/u_rca_seq_add.sv
// Word-serial multi-word unsigned adder, LS word first, one sum word per accepted beat.
// Optional transaction length check enabled by defining SEQADD_LEN_CHECK_EN.
module u_rca_seq_add
    import u_rca_seq_add_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_a,
    input  logic [WORD_W-1:0] s_b,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_sum,
    output logic              m_last,
    output logic              m_cout,
    output logic              m_len_err
);

    if (WORD_W < 1 || NUM_WORDS < 1) begin : g_bad_cfg
        $error("u_rca_seq_add: WORD_W and NUM_WORDS must both be >= 1");
    end

    state_t            state_q;
    logic              carry_q;
    logic              cin;
    logic              accept;
    logic [WORD_W-1:0] sum;
    logic              co;
    logic              len_err_d;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign cin     = (state_q == CHAIN) ? carry_q : 1'b0;

    u_rca_cin #(
        .WORD_W (WORD_W)
    ) u_core (
        .a    (s_a),
        .b    (s_b),
        .cin  (cin),
        .sum  (sum),
        .cout (co)
    );

`ifdef SEQADD_LEN_CHECK_EN
    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    logic [CNT_W-1:0] cnt_q;

    // cnt_q counts the beats before the current one, so a good last beat sees NUM_WORDS-1;
    // saturating at NUM_WORDS still flags over-long transactions.
    assign len_err_d = s_last && (cnt_q != CNT_W'(NUM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            if (s_last)
                cnt_q <= '0;
            else if (cnt_q != CNT_W'(NUM_WORDS))
                cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign len_err_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FIRST;
            carry_q   <= 1'b0;
            m_valid   <= 1'b0;
            m_sum     <= '0;
            m_last    <= 1'b0;
            m_cout    <= 1'b0;
            m_len_err <= 1'b0;
        end else if (accept) begin
            m_valid   <= 1'b1;
            m_sum     <= sum;
            m_last    <= s_last;
            m_cout    <= s_last ? co : 1'b0;
            m_len_err <= len_err_d;
            carry_q   <= s_last ? 1'b0 : co;
            case (state_q)
                FIRST: if (!s_last) state_q <= CHAIN;
                CHAIN: if (s_last)  state_q <= FIRST;
            endcase
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_u_rca_seq_add.sv
// Table-driven and scoreboarded bench for u_rca_seq_add (WORD_W=32, NUM_WORDS=4).
module tb_u_rca_seq_add;

    localparam int W  = 32;
    localparam int NW = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         last;
        logic         cout;
        logic         err;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_a;
    logic [W-1:0] s_b;
    logic         s_last;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_sum;
    logic         m_last;
    logic         m_cout;
    logic         m_len_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int   tb_words = 0;
    exp_t sb_q[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    u_rca_seq_add #(
        .WORD_W    (W),
        .NUM_WORDS (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sum     (m_sum),
        .m_last    (m_last),
        .m_cout    (m_cout),
        .m_len_err (m_len_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Drives one beat and, once accepted, queues its expected result.
    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last,
                              input logic [W-1:0] esum, input logic ecout);
        exp_t e;
        int   n;
        s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n >= 200) break;
        end
        if (n >= 200) begin
            check("accept_timeout", 64'(n), 64'(0));
        end else begin
            tb_words++;
            e.sum  = esum;
            e.last = last;
            e.cout = ecout;
`ifdef SEQADD_LEN_CHECK_EN
            e.err  = last && (tb_words != NW);
`else
            e.err  = 1'b0;
`endif
            if (last) tb_words = 0;
            sb_q.push_back(e);
            @(posedge clk);
        end
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic random_tx(input int len);
        logic [W-1:0] a, b;
        logic [W:0]   t;
        logic         carry = 1'b0;
        logic         last;
        for (int w = 0; w < len; w++) begin
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 3) == 0) b = ~a;
            last = (w == len - 1);
            t    = {1'b0, a} + {1'b0, b} + (W+1)'(carry);
            drive_beat(a, b, last, t[W-1:0], last ? t[W] : 1'b0);
            carry = last ? 1'b0 : t[W];
        end
    endtask

    initial begin
        int    lens[5];
        exp_t  e;
        exp_t  got;
        lens = '{3, 4, 5, 1, 2};

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b1};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0};
        tbl[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b1};
        tbl[4] = '{32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 1'b0};
        tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0};
        tbl[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000001, 1'b0};
        tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0};
        tbl[8] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};

        rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && m_valid && m_ready) begin
                    got = '{m_sum, m_last, m_cout, m_len_err};
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", 64'(got), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("beat", 64'(got), 64'(e));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_sum", 64'(m_sum), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_m_cout", 64'(m_cout), 64'(0));
        check("rst_m_len_err", 64'(m_len_err), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table vectors, full throughput
        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++)
            drive_beat(tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].sum, tbl[i].cout);
        wait_drain();

        // Sink stall mid-transaction: outputs and carry must hold
        rdy_mode = 2;
        @(posedge clk);
        #1;
        drive_beat(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_s_ready", 64'(s_ready), 64'(0));
            check("stall_m_valid", 64'(m_valid), 64'(1));
            check("stall_m_sum", 64'(m_sum), 64'(0));
        end
        rdy_mode = 0;
        drive_beat(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0);
        wait_drain();

        // Reset after a carry-producing non-last word discards the transaction
        rdy_mode = 2;
        @(posedge clk);
        #1;
        drive_beat(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(sb_q.pop_front());
        tb_words = 0;
        check("rst_mid_m_valid", 64'(m_valid), 64'(0));
        check("rst_mid_m_sum", 64'(m_sum), 64'(0));
        rdy_mode = 0;
        drive_beat(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0);
        wait_drain();

        // Fixed lengths around NUM_WORDS, then random lengths with backpressure
        for (int i = 0; i < 5; i++) random_tx(lens[i]);
        wait_drain();
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) random_tx(int'($urandom_range(1, 6)));
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
